// File: rtl/firebird7_in_gate1_tessent_tdr_mux_ctrl_w3_if.sv
// IJTAG scan-control and mux-facing signal bundle for the gate1 TDR.
// master: the scan-network / test-controller side that drives sel/ce/se/ue/si.
// slave:  the TDR itself.
interface firebird7_in_gate1_tessent_tdr_mux_ctrl_w3_if #(
    parameter int DATA_WIDTH = 3
);
    logic                  ijtag_sel;
    logic                  ijtag_ce;
    logic                  ijtag_se;
    logic                  ijtag_ue;
    logic                  ijtag_si;
    logic                  ijtag_so;
    logic [DATA_WIDTH-1:0] functional_data_in;
    logic                  ijtag_select;
    logic [DATA_WIDTH-1:0] ijtag_data_out;
    logic                  update_reject;

    modport master (
        output ijtag_sel,
        output ijtag_ce,
        output ijtag_se,
        output ijtag_ue,
        output ijtag_si,
        output functional_data_in,
        input  ijtag_so,
        input  ijtag_select,
        input  ijtag_data_out,
        input  update_reject
    );

    modport slave (
        input  ijtag_sel,
        input  ijtag_ce,
        input  ijtag_se,
        input  ijtag_ue,
        input  ijtag_si,
        input  functional_data_in,
        output ijtag_so,
        output ijtag_select,
        output ijtag_data_out,
        output update_reject
    );
endinterface

// File: rtl/firebird7_in_gate1_tessent_tdr_mux_ctrl_w3.sv
// IJTAG TDR feeding the 3-bit gate1 IJTAG data mux.
// Scan chain sr[L-1:0], L = DATA_WIDTH+1: sr[L-1] is the select field,
// sr[DATA_WIDTH-1:0] the data field. Update-stage flops drive the mux
// select and IJTAG data inputs; capture observes the functional data
// net together with the current select.
// Optional update guard: define FIREBIRD7_TDR_UPDATE_GUARD_EN to reject
// updates that were not preceded by exactly L shifts since the last
// capture/update/reset (sticky update_reject flag). Without the macro every
// update applies and update_reject is tied low.
module firebird7_in_gate1_tessent_tdr_mux_ctrl_w3 #(
    parameter int                    DATA_WIDTH   = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA   = '0,
    parameter logic                  RESET_SELECT = 1'b0
) (
    input  logic ijtag_tck,
    input  logic ijtag_reset,
    firebird7_in_gate1_tessent_tdr_mux_ctrl_w3_if.slave tdr
);

    localparam int L = DATA_WIDTH + 1;

    logic [L-1:0]          sr_q;
    logic [L-1:0]          sr_d;
    logic                  sel_q;
    logic                  sel_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    logic capture_en;
    logic shift_en;
    logic update_en;
    logic update_ok;

    // Every action is qualified by the TDR being on the active scan path;
    // capture has priority over shift when both are requested.
    always_comb begin
        capture_en = tdr.ijtag_sel & tdr.ijtag_ce;
        shift_en   = tdr.ijtag_sel & tdr.ijtag_se & ~tdr.ijtag_ce;
        update_en  = tdr.ijtag_sel & tdr.ijtag_ue;
    end

    // Shift register next state: capture, shift (LSB out first) or hold.
    always_comb begin
        sr_d = sr_q;
        if (capture_en) begin
            sr_d = {sel_q, tdr.functional_data_in};
        end else if (shift_en) begin
            sr_d = {tdr.ijtag_si, sr_q[L-1:1]};
        end
    end

    // Update stage takes the pre-edge chain contents, even when the chain
    // is also capturing or shifting in the same cycle.
    always_comb begin
        sel_d  = sel_q;
        data_d = data_q;
        if (update_en && update_ok) begin
            sel_d  = sr_q[L-1];
            data_d = sr_q[DATA_WIDTH-1:0];
        end
    end

`ifdef FIREBIRD7_TDR_UPDATE_GUARD_EN

    localparam int              CW       = $clog2(L + 2);
    localparam logic [CW-1:0]   CNT_FULL = CW'(L);
    localparam logic [CW-1:0]   CNT_SAT  = CW'(L + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          reject_q;
    logic          reject_d;

    assign update_ok = (cnt_q == CNT_FULL);

    // Shift counter: cleared by capture and by any update (accepted or
    // not), otherwise counts shift cycles and parks at L+1 so that an
    // over-long shift is still distinguishable from a complete load.
    always_comb begin
        cnt_d = cnt_q;
        if (capture_en) begin
            cnt_d = '0;
        end else if (shift_en && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (update_en) begin
            cnt_d = '0;
        end
    end

    // Reject flag latches on any refused update and holds until reset.
    always_comb begin
        reject_d = reject_q | (update_en & ~update_ok);
    end

    // Guard state registers.
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            cnt_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            reject_q <= reject_d;
        end
    end

    assign tdr.update_reject = reject_q;

`else

    assign update_ok         = 1'b1;
    assign tdr.update_reject = 1'b0;

`endif

    // Chain and update-stage registers; reset overrides all scan actions.
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            sr_q   <= '0;
            sel_q  <= RESET_SELECT;
            data_q <= RESET_DATA;
        end else begin
            sr_q   <= sr_d;
            sel_q  <= sel_d;
            data_q <= data_d;
        end
    end

    assign tdr.ijtag_so       = sr_q[0];
    assign tdr.ijtag_select   = sel_q;
    assign tdr.ijtag_data_out = data_q;

endmodule
